// File: rtl/uart_rx_ctrl.sv
// UART receive frame sequencer: owns the oversample edge counter and bit counter,
// strobes the sampler/deserializer/checkers and reports frame completion or error.
module uart_rx_ctrl #(
    parameter int unsigned PRESC_W   = 6,
    parameter int unsigned DATA_BITS = 8
) (
    input  logic               clk_RX,
    input  logic               rst,
    input  logic               RX_IN,
    input  logic [PRESC_W-1:0] Prescale,
    input  logic               PAR_EN,
    input  logic               Strt_glitch,
    input  logic               Parity_Error,
    input  logic               Stp_err,
    output logic               dat_samp_en,
    output logic [PRESC_W-1:0] edge_cnt,
    output logic               strt_chk_en,
    output logic               deser_en,
    output logic               par_chk_en,
    output logic               stp_chk_en,
    output logic               data_valid,
    output logic               frame_err,
    output logic               par_err
);

    localparam int unsigned BIT_W = $clog2(DATA_BITS + 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } state_e;

    state_e             state_q, state_d;
    logic [PRESC_W-1:0] edge_q, edge_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [BIT_W-1:0]   bit_q, bit_d;
    logic               par_en_q, par_en_d;
    logic               par_flag_q, par_flag_d;
    logic               strt_chk_d, deser_d, par_chk_d, stp_chk_d;
    logic               data_valid_d, frame_err_d, par_err_d;
    logic               edge_last, strobe_pt;

    assign edge_last = (edge_q == presc_q - PRESC_W'(1));

    always_comb begin
        state_d      = state_q;
        edge_d       = edge_q;
        presc_d      = presc_q;
        bit_d        = bit_q;
        par_en_d     = par_en_q;
        par_flag_d   = par_flag_q;
        data_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        par_err_d    = 1'b0;

        if (state_q != StIdle) begin
            edge_d = edge_last ? '0 : edge_q + PRESC_W'(1);
        end

        unique case (state_q)
            StIdle: begin
                if (!RX_IN) begin
                    state_d    = StStart;
                    edge_d     = '0;
                    presc_d    = Prescale;
                    par_en_d   = PAR_EN;
                    par_flag_d = 1'b0;
                end
            end
            StStart: begin
                if (edge_last) begin
                    // A high start sample is treated as line noise, not a frame error.
                    state_d = Strt_glitch ? StIdle : StData;
                    bit_d   = '0;
                end
            end
            StData: begin
                if (edge_last) begin
                    bit_d = bit_q + BIT_W'(1);
                    if (bit_q == BIT_W'(DATA_BITS - 1)) begin
                        state_d = par_en_q ? StParity : StStop;
                    end
                end
            end
            StParity: begin
                if (edge_last) begin
                    par_flag_d = Parity_Error;
                    state_d    = StStop;
                end
            end
            StStop: begin
                if (edge_last) begin
                    data_valid_d = !Stp_err && !(par_en_q && par_flag_q);
                    frame_err_d  = Stp_err;
                    par_err_d    = par_en_q && par_flag_q;
                    if (!RX_IN) begin
                        state_d    = StStart;
                        edge_d     = '0;
                        presc_d    = Prescale;
                        par_en_d   = PAR_EN;
                        par_flag_d = 1'b0;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Strobes are registered, so decode them from the next-state view of the counter.
    assign strobe_pt  = (edge_d == presc_d - PRESC_W'(2));
    assign strt_chk_d = (state_d == StStart)  && strobe_pt;
    assign deser_d    = (state_d == StData)   && strobe_pt;
    assign par_chk_d  = (state_d == StParity) && strobe_pt;
    assign stp_chk_d  = (state_d == StStop)   && strobe_pt;

    always_ff @(posedge clk_RX or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            edge_q      <= '0;
            presc_q     <= '0;
            bit_q       <= '0;
            par_en_q    <= 1'b0;
            par_flag_q  <= 1'b0;
            strt_chk_en <= 1'b0;
            deser_en    <= 1'b0;
            par_chk_en  <= 1'b0;
            stp_chk_en  <= 1'b0;
            data_valid  <= 1'b0;
            frame_err   <= 1'b0;
            par_err     <= 1'b0;
        end else begin
            state_q     <= state_d;
            edge_q      <= edge_d;
            presc_q     <= presc_d;
            bit_q       <= bit_d;
            par_en_q    <= par_en_d;
            par_flag_q  <= par_flag_d;
            strt_chk_en <= strt_chk_d;
            deser_en    <= deser_d;
            par_chk_en  <= par_chk_d;
            stp_chk_en  <= stp_chk_d;
            data_valid  <= data_valid_d;
            frame_err   <= frame_err_d;
            par_err     <= par_err_d;
        end
    end

    assign dat_samp_en = (state_q != StIdle);
    assign edge_cnt    = edge_q;

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
Frame-sequencing controller for the UART receiver. It owns the oversampling edge counter and bit counter and walks the frame through start, data, optional parity and stop. It pulses the enables that drive the sampler, deserializer, start/parity/stop checkers. It issues data_valid when a frame completes without error, or a frame-error/parity-error status pulse when it does not.

Parameters:
PRESC_W, 6, width of Prescale and the internal edge counter.
DATA_BITS, 8, data bits per frame (LSB first).

Ports:
clk_RX  input  1  receiver oversampling clock.
rst  input  1  asynchronous active-low reset.
RX_IN  input  1  serial line, already synchronised; idle high.
Prescale  input  PRESC_W  oversampling ratio; legal values 8, 16, 32.
PAR_EN  input  1  1 = frame carries a parity bit.
Strt_glitch  input  1  registered start-checker result (1 = sampled start bit was high).
Parity_Error  input  1  registered parity-checker result; updates the cycle after par_chk_en.
Stp_err  input  1  registered stop-checker result (1 = sampled stop bit was low).
dat_samp_en  output  1  sampler enable (majority-of-3 around mid-bit).
edge_cnt  output  PRESC_W  current oversample index within the bit, 0..Prescale-1.
strt_chk_en  output  1  one-cycle start-check strobe.
deser_en  output  1  one-cycle deserializer shift strobe.
par_chk_en  output  1  one-cycle parity-check strobe.
stp_chk_en  output  1  one-cycle stop-check strobe.
data_valid  output  1  one-cycle pulse: P_DATA is valid and error-free.
frame_err  output  1  one-cycle pulse: stop bit low.
par_err  output  1  one-cycle pulse: parity mismatch (PAR_EN frames only).

Behaviour:
- Reset (rst low, async): state IDLE; edge_cnt=0, bit counter=0; all outputs 0. Reset mid-frame abandons the frame with no data_valid or error pulse.
- Outputs are registered, except dat_samp_en and edge_cnt, which are decoded from registered state.
- Prescale and PAR_EN are latched on IDLE->START. Changes mid-frame are ignored until the next frame.
- Every bit period lasts exactly P = latched Prescale cycles. edge_cnt runs 0..P-1, wraps to 0 at P-1 and is cleared on entry to START.
- dat_samp_en = 1 in every state except IDLE.
- Check/shift strobe point is edge_cnt==P-2. Checker results are read at edge_cnt==P-1.
- IDLE: dat_samp_en=0. On RX_IN==0 go to START next cycle with edge_cnt=0.
- START: strt_chk_en at P-2. At P-1: if Strt_glitch, go to IDLE silently (no error pulse); else go to DATA, bit counter=0.
- DATA: deser_en at P-2. At P-1, increment the bit counter. After bit DATA_BITS-1, go to PARITY if PAR_EN, else STOP.
- PARITY: par_chk_en at P-2. At P-1, capture Parity_Error into an internal flag and go to STOP.
- STOP: stp_chk_en at P-2. At P-1, the following are registered and visible on the next cycle:
  - data_valid=1 if !Stp_err and !(PAR_EN && flag).
  - frame_err=Stp_err.
  - par_err=PAR_EN && flag.
  - frame_err and par_err may pulse together; data_valid never pulses with either.
- After STOP P-1:
  - If RX_IN==0 on that cycle, go directly to START (back-to-back frames, edge_cnt=0).
  - Else go to IDLE.
- Total latency from the first START cycle to the data_valid pulse: (10+PAR_EN)*P cycles.
- The internal parity flag is cleared on entry to START.
- Break condition (RX_IN held low): ends in frame_err, then re-enters START; no hang.

Test Plan:
- P=8, PAR_EN=1, data 0xA5, correct parity bit, stop=1 -> exactly one data_valid, 88 cycles after the START entry; one deser_en per data bit (8 total); frame_err=par_err=0.
- P=16, PAR_EN=0, data 0x3C -> data_valid 160 cycles after START entry; par_chk_en never asserted.
- RX_IN low for 3 cycles only (glitch), P=8 -> strt_chk_en once, return to IDLE, no data_valid and no error pulses.
- P=8, PAR_EN=1, wrong parity bit -> par_err pulse, no data_valid. Then with stop=0 -> frame_err and par_err pulse together.
- Two back-to-back frames 0x01, 0xFE with no idle between them, P=32 -> two data_valid pulses exactly 320 cycles apart.
- rst asserted during DATA bit 4, then released -> all outputs 0 immediately; next clean frame 0x55 is received correctly.
